issue_buffer: RTL
=================

# issue_buffer

Instruction buffer between fetch/decode and the dual-issue stage. Accepts up to two decoded instructions per cycle with their control bus, branch prediction and PC. Presents the two oldest entries as issue slots 0 and 1, in program order. When the issue stage takes only slot 0 (issue-1 stall), the slot-1 instruction is retained and moves into slot 0 on the next cycle.

## Interface
- DEPTH, 8, number of single-instruction entries; power of two, ≥4
- clock_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all contents (mispredict/redirect)
- in_valid0_i, in_valid1_i  in  1 each  write lanes; lane 1 is meaningful only with lane 0
- in_inst0_i, in_inst1_i  in  32 each  instruction words; lane 0 is older
- in_ctrl0_i, in_ctrl1_i  in  `CTRL_BUS each  decoded control
- in_pred0_i, in_pred1_i  in  1 each  predicted taken
- in_pred_tgt0_i, in_pred_tgt1_i  in  32 each  predicted target
- in_pc0_i, in_pc1_i  in  32 each  PCs
- in_ready_o  out  1  buffer can accept a pair this cycle
- stall_all_i  in  1  backend stall; consume nothing
- issue1_stall_i  in  1  issue stage accepted slot 0 only
- out_valid0_o, out_valid1_o  out  1 each  slot valid
- out_inst0_o, out_inst1_o  out  32 each  slot instruction; 0x00000013 when invalid
- out_ctrl0_o, out_ctrl1_o  out  `CTRL_BUS each  slot control; all-zero when invalid
- out_pred0_o, out_pred1_o, out_pred_tgt0_o, out_pred_tgt1_o, out_pc0_o, out_pc1_o  out  1/32  slot prediction and PC; zero when invalid
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular register array with entry = {inst, ctrl, pred, pred_tgt, pc}. State is rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap mod DEPTH) and count.
- in_ready_o = (DEPTH − count ≥ 2), derived combinationally from count. A single-instruction write is also refused when only one entry is free.
- Write accept = in_ready_o & in_valid0_i & !flush_i.
  - Lane 0 is written at wr_ptr and lane 1 (if in_valid1_i) at wr_ptr+1.
  - wr_ptr advances by 1 or 2.
  - in_valid1_i without in_valid0_i writes nothing and is flagged by a simulation assertion.
- Slots read entry rd_ptr (slot 0) and rd_ptr+1 (slot 1), with wrap.
  - out_valid0_o = count≥1; out_valid1_o = count≥2.
  - Invalid slots drive NOP/zero so downstream dependency logic sees no REGWRITE.
- Consumed count = 0 if stall_all_i; else 2 if out_valid1_o & !issue1_stall_i; else 1 if out_valid0_o; else 0. rd_ptr advances by the consumed count.
- count_next = count + written − consumed. Simultaneous write and consume in one cycle is legal, including at wrap-around.
- flush_i has priority over everything: rd_ptr, wr_ptr and count go to 0 at the next edge, and same-cycle writes and consumes are discarded. Storage contents need not be cleared.
- Reset (asynchronous, any time): pointers and count = 0. Outputs are then out_valid*=0, NOP/zero slot payloads, in_ready_o=1, count_o=0. Storage is not reset.

## Timing
- Write at edge N is visible on the slot outputs in cycle N+1; there is no bypass from in_* to out_*. Minimum latency is 1 cycle.
- Slot outputs are a combinational mux of registered storage and pointers; there is no path from in_* to out_*.
- stall_all_i and issue1_stall_i take effect on the edge that ends the cycle in which they are asserted.
- After issue1_stall_i with 2 valid entries, the former slot-1 entry appears in slot 0 in the next cycle.
- Full boundary: at count = DEPTH−1, in_ready_o=0 even if a consume occurs that cycle. Ready is not predicted from the consume.
- Empty boundary: at count = 0 the consume is 0 regardless of the stall inputs, and there are no underflow pointer moves.
- Reset deasserts asynchronously. The first write is accepted on the first clock edge after reset_n_i rises.

## Test plan
- **Basic write:** after reset, write pair PC 0x00/0x04 at cycle 1 → cycle 2: out_valid0/1=1, out_pc0=0x00, out_pc1=0x04, count_o=2; with no stalls → count_o=0 at cycle 3.
- **Partial issue:** buffer holds PCs 0x00, 0x04, 0x08 with issue1_stall_i=1 for one cycle → next cycle slot0 PC=0x04, slot1 PC=0x08, count_o=2.
- **Fill to full:** with stall_all_i=1, write four pairs into DEPTH=8 → count_o=8, in_ready_o=0. A fifth pair is dropped, with no pointer change. Release the stall → PCs drain in order 0x00…0x1C, two per cycle.
- **Wrap-around:** run 20 pairs through with alternating issue1_stall_i → output PC sequence strictly increasing by 4 with no gaps or duplicates, and count_o never above 8.
- **Flush:** with count_o=5, assert flush_i together with a valid write → next cycle count_o=0 and out_valid0=0 with out_inst0=0x00000013; a write one cycle later appears normally.
- **Mid-operation reset:** pull reset_n_i low between edges with count_o=6 → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_buffer_if.sv
// Fetch/decode to dual-issue bus for the issue buffer: two write lanes, two issue slots,
// flow control and occupancy.
interface issue_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int CTRL_W = 16
);
    logic                       flush_i;
    logic                       in_valid0_i;
    logic                       in_valid1_i;
    logic [31:0]                in_inst0_i;
    logic [31:0]                in_inst1_i;
    logic [CTRL_W-1:0]          in_ctrl0_i;
    logic [CTRL_W-1:0]          in_ctrl1_i;
    logic                       in_pred0_i;
    logic                       in_pred1_i;
    logic [31:0]                in_pred_tgt0_i;
    logic [31:0]                in_pred_tgt1_i;
    logic [31:0]                in_pc0_i;
    logic [31:0]                in_pc1_i;
    logic                       in_ready_o;
    logic                       stall_all_i;
    logic                       issue1_stall_i;
    logic                       out_valid0_o;
    logic                       out_valid1_o;
    logic [31:0]                out_inst0_o;
    logic [31:0]                out_inst1_o;
    logic [CTRL_W-1:0]          out_ctrl0_o;
    logic [CTRL_W-1:0]          out_ctrl1_o;
    logic                       out_pred0_o;
    logic                       out_pred1_o;
    logic [31:0]                out_pred_tgt0_o;
    logic [31:0]                out_pred_tgt1_o;
    logic [31:0]                out_pc0_o;
    logic [31:0]                out_pc1_o;
    logic [$clog2(DEPTH):0]     count_o;

    modport master (
        output flush_i, in_valid0_i, in_valid1_i, in_inst0_i, in_inst1_i,
               in_ctrl0_i, in_ctrl1_i, in_pred0_i, in_pred1_i,
               in_pred_tgt0_i, in_pred_tgt1_i, in_pc0_i, in_pc1_i,
               stall_all_i, issue1_stall_i,
        input  in_ready_o, out_valid0_o, out_valid1_o, out_inst0_o, out_inst1_o,
               out_ctrl0_o, out_ctrl1_o, out_pred0_o, out_pred1_o,
               out_pred_tgt0_o, out_pred_tgt1_o, out_pc0_o, out_pc1_o, count_o
    );

    modport slave (
        input  flush_i, in_valid0_i, in_valid1_i, in_inst0_i, in_inst1_i,
               in_ctrl0_i, in_ctrl1_i, in_pred0_i, in_pred1_i,
               in_pred_tgt0_i, in_pred_tgt1_i, in_pc0_i, in_pc1_i,
               stall_all_i, issue1_stall_i,
        output in_ready_o, out_valid0_o, out_valid1_o, out_inst0_o, out_inst1_o,
               out_ctrl0_o, out_ctrl1_o, out_pred0_o, out_pred1_o,
               out_pred_tgt0_o, out_pred_tgt1_o, out_pc0_o, out_pc1_o, count_o
    );
endinterface

// File: rtl/issue_buffer.sv
// Circular instruction buffer feeding a dual-issue stage: two writes in, the two oldest
// entries presented as issue slots, partial (slot-0-only) issue supported.
module issue_buffer #(
    parameter int DEPTH  = 8,
    parameter int CTRL_W = 16
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    issue_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 32 + CTRL_W + 1 + 32 + 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [EW-1:0] entry_t;

    function automatic entry_t pack_entry(input logic [31:0] inst, input logic [CTRL_W-1:0] ctrl,
                                          input logic pred, input logic [31:0] tgt,
                                          input logic [31:0] pc);
        return {inst, ctrl, pred, tgt, pc};
    endfunction

    entry_t          mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic            ready_s;
    logic            wr0_s;
    logic            wr1_s;
    logic [1:0]      wr_num_s;
    logic [1:0]      rd_num_s;
    logic            slot_v0_s;
    logic            slot_v1_s;
    logic [PW-1:0]   rd_ptr1_s;
    logic [PW-1:0]   wr_ptr1_s;
    entry_t          slot0_s;
    entry_t          slot1_s;

    // Flow control, write enables and consume count, all from current state and inputs.
    always_comb begin
        ready_s   = (count_r <= CW'(DEPTH - 2));
        wr0_s     = ready_s & bus.in_valid0_i & ~bus.flush_i;
        wr1_s     = wr0_s & bus.in_valid1_i;
        slot_v0_s = (count_r >= CW'(1));
        slot_v1_s = (count_r >= CW'(2));
        rd_ptr1_s = rd_ptr_r + PW'(1);
        wr_ptr1_s = wr_ptr_r + PW'(1);
        if (wr1_s) begin
            wr_num_s = 2'd2;
        end else if (wr0_s) begin
            wr_num_s = 2'd1;
        end else begin
            wr_num_s = 2'd0;
        end
        // An empty buffer consumes nothing whatever the stall inputs say.
        if (bus.stall_all_i) begin
            rd_num_s = 2'd0;
        end else if (slot_v1_s && !bus.issue1_stall_i) begin
            rd_num_s = 2'd2;
        end else if (slot_v0_s) begin
            rd_num_s = 2'd1;
        end else begin
            rd_num_s = 2'd0;
        end
    end

    // Pointer and occupancy state; flush discards same-cycle writes and consumes.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (bus.flush_i) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_r + PW'(rd_num_s);
            wr_ptr_r <= wr_ptr_r + PW'(wr_num_s);
            count_r  <= count_r + CW'(wr_num_s) - CW'(rd_num_s);
        end
    end

    // Entry storage; left unreset since count gates every read.
    always_ff @(posedge clock_i) begin
        if (wr0_s) begin
            mem_r[wr_ptr_r] <= pack_entry(bus.in_inst0_i, bus.in_ctrl0_i, bus.in_pred0_i,
                                          bus.in_pred_tgt0_i, bus.in_pc0_i);
        end
        if (wr1_s) begin
            mem_r[wr_ptr1_s] <= pack_entry(bus.in_inst1_i, bus.in_ctrl1_i, bus.in_pred1_i,
                                           bus.in_pred_tgt1_i, bus.in_pc1_i);
        end
    end

    // Slot muxes: invalid slots show a NOP with zero control so no REGWRITE leaks downstream.
    always_comb begin
        slot0_s = slot_v0_s ? mem_r[rd_ptr_r]  : pack_entry(NOP_INST, {CTRL_W{1'b0}}, 1'b0, 32'h0, 32'h0);
        slot1_s = slot_v1_s ? mem_r[rd_ptr1_s] : pack_entry(NOP_INST, {CTRL_W{1'b0}}, 1'b0, 32'h0, 32'h0);
        {bus.out_inst0_o, bus.out_ctrl0_o, bus.out_pred0_o, bus.out_pred_tgt0_o, bus.out_pc0_o} = slot0_s;
        {bus.out_inst1_o, bus.out_ctrl1_o, bus.out_pred1_o, bus.out_pred_tgt1_o, bus.out_pc1_o} = slot1_s;
        bus.out_valid0_o = slot_v0_s;
        bus.out_valid1_o = slot_v1_s;
    end

    assign bus.in_ready_o = ready_s;
    assign bus.count_o    = count_r;

    issue_buffer_chk u_chk (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .in_valid0 (bus.in_valid0_i),
        .in_valid1 (bus.in_valid1_i)
    );
endmodule

// Protocol checks for the write lanes.
module issue_buffer_chk (
    input logic clock_i,
    input logic reset_n_i,
    input logic in_valid0,
    input logic in_valid1
);
    // Lane 1 without lane 0 is dropped by the buffer and is an upstream bug.
    lane1_needs_lane0: assert property (@(posedge clock_i) disable iff (!reset_n_i)
        !(in_valid1 && !in_valid0));
endmodule
